// File: rtl/case_3_mul_pkg.sv
// case_3_mul_pkg: shared encodings and width helper for the pipelined saturating multiplier.
package case_3_mul_pkg;

    // mode[0] = din0 signed, mode[1] = din1 signed
    localparam logic [1:0] MODE_UU = 2'b00;
    localparam logic [1:0] MODE_SU = 2'b01;
    localparam logic [1:0] MODE_US = 2'b10;
    localparam logic [1:0] MODE_SS = 2'b11;

    localparam int SAT_WRAP  = 0;
    localparam int SAT_CLAMP = 1;

    // Each operand gains one extension bit, so the signed product of the
    // extended operands is exact in w0+w1+2 bits.
    function automatic int prod_width(input int w0, input int w1);
        return w0 + w1 + 2;
    endfunction

endpackage

// File: rtl/case_3_mul_stage_reg.sv
// case_3_mul_stage_reg: one elastic pipeline stage (valid + data) with combinational ready.
//   i_clk, i_rst_n      : clock, async active-low reset
//   i_valid, i_data     : upstream transaction
//   o_ready             : stage loads this cycle (ready back to upstream)
//   o_valid, o_data     : held transaction
//   i_ready             : downstream takes the held transaction this cycle
module case_3_mul_stage_reg #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Load when empty or when the current contents leave this cycle.
    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid)
                r_data <= i_data;
        end
    end

endmodule

// File: rtl/case_3_mul_pipe_sat.sv
// case_3_mul_pipe_sat: pipelined signed/unsigned multiplier with wrap or saturate and overflow flag.
//   ap_clk, ap_rst_n     : clock, async active-low reset
//   in_valid, in_ready   : input handshake
//   din0, din1, mode     : operands; mode[0]/mode[1] mark din0/din1 as signed
//   out_valid, out_ready : output handshake
//   dout, ovf            : result and out-of-range flag (qualified by out_valid)
module case_3_mul_pipe_sat
    import case_3_mul_pkg::*;
#(
    parameter int din0_WIDTH = 6,
    parameter int din1_WIDTH = 6,
    parameter int dout_WIDTH = 6,
    parameter int NUM_STAGE  = 2,
    parameter int SAT        = 1
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic [1:0]            mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf
);

    localparam int PW = prod_width(din0_WIDTH, din1_WIDTH);
    localparam int SW = PW + 1;
    localparam int DW = dout_WIDTH;

    logic signed [din0_WIDTH:0] w_a;
    logic signed [din1_WIDTH:0] w_b;
    logic signed [PW-1:0]       w_p;
    logic [SW-1:0]              w_q [0:NUM_STAGE-1];
    logic [NUM_STAGE:0]         w_v;
    logic [NUM_STAGE:0]         w_r;
    logic                       w_sgn;
    logic [PW-1:0]              w_p_pre;
    logic [PW-DW:0]             w_hi;
    logic                       w_ovf;
    logic [DW-1:0]              w_bound;
    logic [DW-1:0]              w_res;
    logic [DW:0]                w_fin;
    logic [DW:0]                w_out;

    assign w_a   = {mode[0] & din0[din0_WIDTH-1], din0};
    assign w_b   = {mode[1] & din1[din1_WIDTH-1], din1};
    assign w_p   = PW'(w_a) * PW'(w_b);
    assign w_q[0] = {mode != MODE_UU, w_p};

    // Range check and clamp operate on whatever feeds the last register:
    // the raw product for a single stage, otherwise the second-to-last stage.
    assign {w_sgn, w_p_pre} = w_q[NUM_STAGE-1];
    assign w_hi    = w_p_pre[PW-1:DW-1];
    assign w_ovf   = w_sgn ? !(&w_hi || !(|w_hi)) : |w_p_pre[PW-1:DW];
    assign w_bound = w_sgn ? (w_p_pre[PW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}})
                           : (w_p_pre[PW-1] ? '0 : '1);
    assign w_res   = (SAT == SAT_CLAMP && w_ovf) ? w_bound : w_p_pre[DW-1:0];
    assign w_fin   = {w_ovf, w_res};

    assign w_v[0]         = in_valid;
    assign w_r[NUM_STAGE] = out_ready;
    assign in_ready       = w_r[0];
    assign out_valid      = w_v[NUM_STAGE];
    assign {ovf, dout}    = w_out;

    for (genvar k = 0; k < NUM_STAGE; k++) begin : g_stage
        if (k == NUM_STAGE - 1) begin : g_last
            case_3_mul_stage_reg #(.WIDTH(DW + 1)) u_stage (
                .i_clk   (ap_clk),
                .i_rst_n (ap_rst_n),
                .i_valid (w_v[k]),
                .o_ready (w_r[k]),
                .i_data  (w_fin),
                .o_valid (w_v[k+1]),
                .i_ready (w_r[k+1]),
                .o_data  (w_out)
            );
        end else begin : g_mid
            case_3_mul_stage_reg #(.WIDTH(SW)) u_stage (
                .i_clk   (ap_clk),
                .i_rst_n (ap_rst_n),
                .i_valid (w_v[k]),
                .o_ready (w_r[k]),
                .i_data  (w_q[k]),
                .o_valid (w_v[k+1]),
                .i_ready (w_r[k+1]),
                .o_data  (w_q[k+1])
            );
        end
    end

endmodule

// File: doc/case_3_mul_pipe_sat.md
Name: case_3_mul_pipe_sat

Overview:
- Parametrised, pipelined multiplier with a runtime choice of signed or unsigned for each operand.
- Output is either truncated (wrap) or saturated to the dout width, with an overflow flag.
- Elastic valid/ready handshake on input and output; downstream backpressure stalls the pipeline without losing data.
- Successor to the combinational fixed-sign multiplier cores used in the generated datapaths; drop-in wherever a multi-cycle, flow-controlled multiply is scheduled.

Parameters:
- din0_WIDTH, 6: operand 0 width, range 2..32.
- din1_WIDTH, 6: operand 1 width, range 2..32.
- dout_WIDTH, 6: result width, range 2..(din0_WIDTH+din1_WIDTH+1).
- NUM_STAGE, 2: pipeline depth in register stages, range 1..8.
- SAT, 1: 1 saturates out-of-range results; 0 truncates to the low dout_WIDTH bits.

Ports:
- ap_clk  in  1  clock; all state on rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block accepts input this cycle.
- din0  in  din0_WIDTH  operand 0.
- din1  in  din1_WIDTH  operand 1.
- mode  in  2  bit0 = din0 signed, bit1 = din1 signed; sampled with the transaction.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- dout  out  dout_WIDTH  result.
- ovf  out  1  exact product not representable in dout; qualified by out_valid.

Behaviour:
- Reset (async assert, sync release): all stage valid bits = 0, all data registers = 0. So out_valid=0, dout=0, ovf=0. in_ready=1 on the first cycle after release.
- Transfer rules: input accepted when in_valid && in_ready; output consumed when out_valid && out_ready.
- Stage k (1..NUM_STAGE) holds {valid, data}. Stage k loads when it is empty or stage k+1 (the consumer, for the last stage) takes its contents this cycle.
- in_ready = stage 1 loads this cycle. The ready chain is combinational, so no bubbles: full throughput of 1 result/cycle while out_ready=1.
- Latency: NUM_STAGE cycles from accept to out_valid when there is no stall. Results leave in acceptance order; no drops, no duplicates.
- Stall: out_ready=0 with the pipe full -> in_ready=0 in the same cycle, and every register holds. dout and ovf stay stable while out_valid && !out_ready.
- Arithmetic:
  - Extend each operand by 1 bit: sign-extend if its mode bit is 1, zero-extend if 0.
  - Compute the signed product P over din0_WIDTH+din1_WIDTH+2 bits; P is exact.
  - Result is signed if mode != 2'b00, otherwise unsigned.
  - Representable range: signed [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1]; unsigned [0, 2^dout_WIDTH-1].
  - ovf = P is outside the range.
  - SAT=1: an out-of-range result clamps to the nearest bound. SAT=0: dout = P[dout_WIDTH-1:0].
- Placement: the product is computed ahead of the stage 1 register; the range check and clamp ahead of the last stage register. With NUM_STAGE=1, both sit ahead of the single register.
- mode is carried with its transaction, so mixing modes back-to-back is legal.
- Reset mid-operation: in-flight transactions are discarded and out_valid drops immediately on assertion. No stale result appears after release.
- in_valid with in_ready=0: the source holds its data (AXI-style). The block does not sample it.

Decomposition:
- Package case_3_mul_pkg holds:
  - mode encoding constants MODE_UU=2'b00, MODE_SU=2'b01, MODE_US=2'b10, MODE_SS=2'b11;
  - localparam function for product width (din0_WIDTH+din1_WIDTH+2);
  - SAT encoding constants.
- Sub-module case_3_mul_stage_reg: one elastic stage (valid + data register, load/hold logic, async active-low reset), parametrised by data width and instantiated NUM_STAGE times in a generate loop. The top level keeps the multiply and clamp logic.

Test Plan (defaults: 6/6/6, NUM_STAGE=2, SAT=1 unless stated):
- mode=11, din0=6'h3D (-3), din1=6'h05 -> 2 cycles later out_valid=1, dout=6'h31 (-15), ovf=0.
- mode=11, din0=7, din1=7 (49) -> dout=6'h1F, ovf=1. Same stimulus with SAT=0 -> dout=6'h31, ovf=1.
- mode=00: 63*63 -> dout=6'h3F, ovf=1; then 7*8 -> dout=6'h38, ovf=0, on back-to-back cycles.
- mode=01, din0=6'h3F (-1), din1=6'h3F (63) -> P=-63 -> dout=6'h20 (-32), ovf=1.
- Stream 8 random transactions with out_ready held low for cycles 3..5:
  - in_ready=0 once both stages are full;
  - dout stable during the stall;
  - all 8 results in order and matching the golden model;
  - 1/cycle throughput after release.
- 2 transactions in flight, pulse ap_rst_n low mid-cycle -> out_valid=0 immediately; after release no output appears, and the next input returns its result after 2 cycles.
